sipo_deserializer: RTL and testbench



---
 rtl/sipo_pkg.sv | 17 +
 rtl/sipo_out_buf.sv | 68 ++++++
 rtl/sipo_deserializer.sv | 99 +++++++++
 tb/tb_sipo_deserializer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver: output buffer
// state encoding, default word width and the bit-counter width helper.
package sipo_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The counter must hold WIDTH itself when a trailing parity bit is framed.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry output register for the deserializer. Holds the last completed
// word behind a valid/ready handshake and raises a sticky overrun flag when
// a word completes while the held one has not been accepted.
// Optional macro PARITY_CHECK_EN adds a parity error flag stored with the word.
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`ifdef PARITY_CHECK_EN
  input  logic             load_perr,
  output logic             parity_err,
`endif
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun
);

  buf_state_t state;

  // Buffer FSM: accept a new word when empty or when the held word is taken
  // in the same cycle; otherwise drop it and flag overrun (set beats clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      parallel_out <= '0;
      overrun      <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      if (overrun_clr) overrun <= 1'b0;
      case (state)
        EMPTY: begin
          if (load) begin
            state        <= FULL;
            parallel_out <= load_data;
`ifdef PARITY_CHECK_EN
            parity_err   <= load_perr;
`endif
          end
        end
        FULL: begin
          if (load && out_ready) begin
            parallel_out <= load_data;
`ifdef PARITY_CHECK_EN
            parity_err   <= load_perr;
`endif
          end else if (load) begin
            overrun <= 1'b1;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver. Captures one bit per bit_valid strobe,
// assembles WIDTH-bit words (MSB- or LSB-first) and hands each completed
// word to a one-entry output buffer with valid/ready handshake.
// Optional macro PARITY_CHECK_EN: each frame carries one trailing even-parity
// bit that is checked but not stored, and a parity_err output is added.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
`ifdef PARITY_CHECK_EN
  output logic             parity_err,
`endif
  input  logic             overrun_clr
);

  localparam int CW = cnt_width(WIDTH);
`ifdef PARITY_CHECK_EN
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    bit_cnt;
  logic             at_last;
  logic             complete;
  logic             shift_en;
`ifdef PARITY_CHECK_EN
  logic             word_perr;
`endif

  // Next shift value, completion detect and the word handed to the buffer;
  // a frame_start strobe always begins a new frame, so it never completes one.
  always_comb begin
    shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], serial_in}
                           : {serial_in, shift_reg[WIDTH-1:1]};
    at_last    = (bit_cnt == LAST) && !frame_start;
    complete   = bit_valid && at_last;
`ifdef PARITY_CHECK_EN
    shift_en   = bit_valid && !at_last;
    word       = shift_reg;
    word_perr  = ^{shift_reg, serial_in};
`else
    shift_en   = bit_valid;
    word       = shift_next;
`endif
  end

  // Shift register and bit counter; stale shift contents need no clearing on
  // resync because a full frame shifts them all out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (shift_en) shift_reg <= shift_next;
      if (frame_start) begin
        bit_cnt <= bit_valid ? CW'(1) : '0;
      end else if (bit_valid) begin
        bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
      end
    end
  end

  assign busy = (bit_cnt != '0);

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk          (clk),
    .reset        (reset),
    .load         (complete),
    .load_data    (word),
`ifdef PARITY_CHECK_EN
    .load_perr    (word_perr),
    .parity_err   (parity_err),
`endif
    .out_ready    (out_ready),
    .overrun_clr  (overrun_clr),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer. Two instances share all inputs:
// one MSB-first, one LSB-first. A queue-based reference model tracks frames
// and the output buffer. Honours PARITY_CHECK_EN when defined.
module tb_sipo_deserializer;

  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b0, bit_valid = 1'b0, frame_start = 1'b0;
  logic out_ready = 1'b0, overrun_clr = 1'b0;
  logic [W-1:0] po_m, po_l;
  logic ov_m, ov_l, busy_m, busy_l, orun_m, orun_l;
`ifdef PARITY_CHECK_EN
  logic perr_m, perr_l;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           frame_q[$];
  logic         m_valid, m_ovr, m_perr;
  logic [W-1:0] m_word_m, m_word_l;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .parallel_out(po_m), .out_valid(ov_m),
    .out_ready(out_ready), .busy(busy_m), .overrun(orun_m),
`ifdef PARITY_CHECK_EN
    .parity_err(perr_m),
`endif
    .overrun_clr(overrun_clr)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .parallel_out(po_l), .out_valid(ov_l),
    .out_ready(out_ready), .busy(busy_l), .overrun(orun_l),
`ifdef PARITY_CHECK_EN
    .parity_err(perr_l),
`endif
    .overrun_clr(overrun_clr)
  );

  task automatic model_reset();
    frame_q.delete();
    m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    m_word_m = '0; m_word_l = '0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic done, pe;
    logic [W-1:0] wm, wl;
    done = 1'b0; pe = 1'b0; wm = '0; wl = '0;
    if (frame_start) frame_q.delete();
    if (bit_valid) begin
      frame_q.push_back(serial_in);
      if (frame_q.size() == FRAME) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = frame_q[i];
          wl[i]     = frame_q[i];
        end
        for (int i = 0; i < FRAME; i++) pe = pe ^ frame_q[i];
        frame_q.delete();
      end
    end
    if (overrun_clr) m_ovr = 1'b0;
    if (done) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1; m_word_m = wm; m_word_l = wl; m_perr = pe;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic s, input logic b, input logic f,
                       input logic r, input logic c);
    serial_in = s; bit_valid = b; frame_start = f; out_ready = r; overrun_clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Send one word MSB-bit first in time; in parity mode a parity bit follows.
  task automatic send_word(input logic [W-1:0] w, input logic pbit,
                           input logic rdy_body, input logic rdy_last);
    logic [W-1:0] v;
    v = w;
`ifdef PARITY_CHECK_EN
    for (int i = W - 1; i >= 0; i--) cycle(v[i], 1'b1, 1'b0, rdy_body, 1'b0);
    cycle(pbit, 1'b1, 1'b0, rdy_last, 1'b0);
`else
    for (int i = W - 1; i >= 1; i--) cycle(v[i], 1'b1, 1'b0, rdy_body, 1'b0);
    cycle(v[0], 1'b1, 1'b0, rdy_last, 1'b0);
    if (pbit === 1'bx) $display("[TB] unexpected parity input");
`endif
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks += 5;
    if (po_m !== '0) begin errors++; $display("[TB] FAIL reset_po_m: got %h want 00", po_m); end
    if (po_l !== '0) begin errors++; $display("[TB] FAIL reset_po_l: got %h want 00", po_l); end
    if (ov_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", ov_m); end
    if (busy_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_m); end
    if (orun_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b want 0", orun_m); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send_word(8'hD0, 1'b1, 1'b1, 1'b1);
    checks += 3;
    if (ov_m !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b want 1", ov_m); end
    if (po_m !== 8'hD0) begin errors++; $display("[TB] FAIL basic_msb: got %h want d0", po_m); end
    if (po_l !== 8'h0B) begin errors++; $display("[TB] FAIL basic_lsb: got %h want 0b", po_l); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ov_m !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_drop: got %b want 0", ov_m); end
  endtask

  task automatic test_sparse();
    logic [FRAME-1:0] bits;
    logic want_busy;
`ifdef PARITY_CHECK_EN
    bits = {8'hD0, 1'b1};
`else
    bits = 8'hD0;
`endif
    for (int s = 0; s < FRAME; s++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(bits[FRAME-1-s], 1'b1, 1'b0, 1'b1, 1'b0);
      want_busy = (s < FRAME - 1);
      checks++;
      if (busy_m !== want_busy) begin
        errors++; $display("[TB] FAIL sparse_busy[%0d]: got %b want %b", s, busy_m, want_busy);
      end
    end
    checks += 2;
    if (ov_m !== 1'b1) begin errors++; $display("[TB] FAIL sparse_valid: got %b want 1", ov_m); end
    if (po_m !== 8'hD0) begin errors++; $display("[TB] FAIL sparse_word: got %h want d0", po_m); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    send_word(8'hAA, 1'b0, 1'b0, 1'b0);
    checks += 3;
    if (ov_m !== 1'b1) begin errors++; $display("[TB] FAIL ovr_first_valid: got %b want 1", ov_m); end
    if (po_m !== 8'hAA) begin errors++; $display("[TB] FAIL ovr_first_word: got %h want aa", po_m); end
    if (po_l !== 8'h55) begin errors++; $display("[TB] FAIL ovr_first_lsb: got %h want 55", po_l); end
    send_word(8'h55, 1'b0, 1'b0, 1'b0);
    checks += 3;
    if (po_m !== 8'hAA) begin errors++; $display("[TB] FAIL ovr_hold_word: got %h want aa", po_m); end
    if (orun_m !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag: got %b want 1", orun_m); end
    if (ov_m !== 1'b1) begin errors++; $display("[TB] FAIL ovr_still_valid: got %b want 1", ov_m); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (orun_m !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b want 0", orun_m); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks += 2;
    if (ov_m !== 1'b0) begin errors++; $display("[TB] FAIL ovr_accept: got %b want 0", ov_m); end
    if (po_m !== 8'hAA) begin errors++; $display("[TB] FAIL ovr_po_held: got %h want aa", po_m); end
  endtask

  task automatic test_resync();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (busy_m !== 1'b1) begin errors++; $display("[TB] FAIL resync_busy: got %b want 1", busy_m); end
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
    checks += 3;
    if (ov_m !== 1'b1) begin errors++; $display("[TB] FAIL resync_valid: got %b want 1", ov_m); end
    if (po_m !== 8'h80) begin errors++; $display("[TB] FAIL resync_msb: got %h want 80", po_m); end
    if (po_l !== 8'h01) begin errors++; $display("[TB] FAIL resync_lsb: got %h want 01", po_l); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (po_m !== 8'h3C) begin errors++; $display("[TB] FAIL b2b_first: got %h want 3c", po_m); end
    send_word(8'hC3, 1'b0, 1'b0, 1'b1);
    checks += 4;
    if (ov_m !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got %b want 1", ov_m); end
    if (po_m !== 8'hC3) begin errors++; $display("[TB] FAIL b2b_second: got %h want c3", po_m); end
    if (po_l !== m_word_l) begin errors++; $display("[TB] FAIL b2b_lsb: got %h want %h", po_l, m_word_l); end
    if (orun_m !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %b want 0", orun_m); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ov_m !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b want 0", ov_m); end
  endtask

  task automatic test_reset_mid();
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (busy_m !== 1'b1) begin errors++; $display("[TB] FAIL rmid_busy_before: got %b want 1", busy_m); end
    if (ov_m !== 1'b1) begin errors++; $display("[TB] FAIL rmid_valid_before: got %b want 1", ov_m); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks += 4;
    if (po_m !== '0) begin errors++; $display("[TB] FAIL rmid_po: got %h want 00", po_m); end
    if (ov_m !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid: got %b want 0", ov_m); end
    if (busy_m !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b want 0", busy_m); end
    if (orun_m !== 1'b0) begin errors++; $display("[TB] FAIL rmid_overrun: got %b want 0", orun_m); end
    @(posedge clk); #1;
    reset = 1'b0;
    send_word(8'h96, 1'b0, 1'b1, 1'b1);
    checks += 3;
    if (ov_m !== 1'b1) begin errors++; $display("[TB] FAIL rmid_new_valid: got %b want 1", ov_m); end
    if (po_m !== 8'h96) begin errors++; $display("[TB] FAIL rmid_new_word: got %h want 96", po_m); end
    if (po_l !== m_word_l) begin errors++; $display("[TB] FAIL rmid_new_lsb: got %h want %h", po_l, m_word_l); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    send_word(8'hD0, 1'b1, 1'b1, 1'b1);
    checks += 2;
    if (po_m !== 8'hD0) begin errors++; $display("[TB] FAIL par_word: got %h want d0", po_m); end
    if (perr_m !== 1'b0) begin errors++; $display("[TB] FAIL par_good: got %b want 0", perr_m); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'hD0, 1'b0, 1'b1, 1'b1);
    checks += 2;
    if (perr_m !== 1'b1) begin errors++; $display("[TB] FAIL par_bad_m: got %b want 1", perr_m); end
    if (perr_l !== 1'b1) begin errors++; $display("[TB] FAIL par_bad_l: got %b want 1", perr_l); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic exp_busy;
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0));
      exp_busy = (frame_q.size() != 0);
      checks += 6;
      if (ov_m !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid_m[%0d]: got %b want %b", n, ov_m, m_valid); end
      if (ov_l !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid_l[%0d]: got %b want %b", n, ov_l, m_valid); end
      if (po_m !== m_word_m) begin errors++; $display("[TB] FAIL rnd_word_m[%0d]: got %h want %h", n, po_m, m_word_m); end
      if (po_l !== m_word_l) begin errors++; $display("[TB] FAIL rnd_word_l[%0d]: got %h want %h", n, po_l, m_word_l); end
      if (orun_m !== m_ovr) begin errors++; $display("[TB] FAIL rnd_overrun[%0d]: got %b want %b", n, orun_m, m_ovr); end
      if (busy_l !== exp_busy) begin errors++; $display("[TB] FAIL rnd_busy[%0d]: got %b want %b", n, busy_l, exp_busy); end
`ifdef PARITY_CHECK_EN
      if (m_valid) begin
        checks++;
        if (perr_m !== m_perr) begin errors++; $display("[TB] FAIL rnd_perr[%0d]: got %b want %b", n, perr_m, m_perr); end
      end
`endif
    end
  endtask

  // Main sequence of scenarios followed by the summary line.
  initial begin
    test_reset();
    test_basic();
    test_sparse();
    test_overrun();
    test_resync();
    test_back_to_back();
    test_reset_mid();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
